mem_arbiter: RTL and testbench

- Responder side of the request-unit protocol. It consumes the iREN/dREN/dWEN strobes that the request unit issues and returns the ihit/dhit acknowledgements.
- It arbitrates the instruction-fetch and data ports onto a single RAM port, with data given priority over instruction.
- It models a fixed RAM access latency with an internal wait counter.
- It sits between the datapath (request unit and caches) and the RAM.

---
 rtl/cpu_types_pkg.sv | 14 +
 rtl/mem_arbiter_if.sv | 44 ++++
 rtl/mem_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types.
//   word_t      : 32-bit machine word used for addresses and data
//   arb_state_t : state encoding of the memory arbiter FSM
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DACC,
    IACC
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the signals between the request unit / caches, the memory
// arbiter and the RAM.
//   CLK, RST         : clock and asynchronous active-high reset
//   iREN/iaddr       : instruction fetch request, level until ihit
//   dREN/dWEN/daddr  : data read/write request, level until dhit
//   dstore           : data to write
//   ihit/dhit        : one-cycle completion pulses
//   iload/dload      : returned read data, valid with the hit
//   ramREN/ramWEN    : RAM strobes
//   ramaddr/ramstore : RAM address and write data
//   ramload          : RAM read data (combinational from ramaddr)
interface mem_arbiter_if (
  input logic CLK,
  input logic RST
);
  import cpu_types_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  ihit;
  logic  dhit;
  word_t iload;
  word_t dload;
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;

  modport arb (
    input  CLK, RST, iREN, iaddr, dREN, dWEN, daddr, dstore, ramload,
    output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport tb (
    input  CLK, RST, ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore,
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload
  );

endinterface

// File: rtl/mem_arbiter.sv
// Memory arbiter: grants one of the data or instruction ports to a single
// RAM port (data has priority), models a fixed RAM latency of LAT cycles
// with a wait counter, and returns one-cycle ihit/dhit pulses.
// Ports:
//   CLK, RST          clock, asynchronous active-high reset
//   iREN, iaddr       instruction read request and address
//   dREN, dWEN        data read / write request (dWEN wins if both set)
//   daddr, dstore     data address and write data
//   ihit, dhit        completion pulses (never together, never in IDLE)
//   iload, dload      read data, valid only with the matching hit
//   ramREN, ramWEN    RAM strobes
//   ramaddr, ramstore RAM address / write data (pass-through of granted port)
//   ramload           RAM read data
// Parameters: LAT in 1..15, CW wide enough that 2**CW > LAT.
//
// state | meaning
// IDLE  | arbitration cycle, no RAM activity, outputs all zero
// DACC  | data port owns the RAM, counting down to dhit
// IACC  | instruction port owns the RAM, counting down to ihit
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int LAT = 2,
  parameter int CW  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic        dhit,
  output logic [31:0] iload,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  localparam logic [CW-1:0] LAST = CW'(LAT - 1);

  arb_state_t    state;
  logic [CW-1:0] cnt;
  logic          dreq;

  assign dreq = dREN | dWEN;

  // A dropped request aborts the access in the same cycle; the next
  // cycle is always an IDLE arbitration cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (dreq)      state <= DACC;
          else if (iREN) state <= IACC;
        end
        DACC: begin
          if (!dreq || cnt == LAST) state <= IDLE;
          else                      cnt   <= cnt + CW'(1);
        end
        IACC: begin
          if (!iREN || cnt == LAST) state <= IDLE;
          else                      cnt   <= cnt + CW'(1);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // RAM signals are pass-through from the granted port, gated by the
  // request still being held so an abort cycle issues no strobe.
  always_comb begin
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DACC: begin
        if (dreq) begin
          ramaddr = daddr;
          if (dWEN) begin
            ramWEN   = 1'b1;
            ramstore = dstore;
          end else begin
            ramREN = 1'b1;
          end
          if (cnt == LAST) begin
            dhit = 1'b1;
            if (!dWEN) dload = ramload;
          end
        end
      end
      IACC: begin
        if (iREN) begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (cnt == LAST) begin
            ihit  = 1'b1;
            iload = ramload;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if bus (.CLK(clk), .RST(rst));

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C22_0004 : (~a ^ 32'h1234_0000);
  endfunction

  assign bus.ramload = mem_model(bus.ramaddr);

  mem_arbiter #(.LAT(2), .CW(4)) u_dut (
    .CLK(clk), .RST(rst),
    .iREN(bus.iREN), .iaddr(bus.iaddr),
    .dREN(bus.dREN), .dWEN(bus.dWEN), .daddr(bus.daddr), .dstore(bus.dstore),
    .ihit(bus.ihit), .dhit(bus.dhit), .iload(bus.iload), .dload(bus.dload),
    .ramREN(bus.ramREN), .ramWEN(bus.ramWEN), .ramaddr(bus.ramaddr),
    .ramstore(bus.ramstore), .ramload(bus.ramload)
  );

  // Sweep instances: LAT=1 and LAT=5 with a shared held data read.
  logic        s_dren = 1'b0;
  logic [31:0] s_daddr = 32'h0000_0500;
  logic        s1_ihit, s1_dhit, s1_ren, s1_wen, s5_ihit, s5_dhit, s5_ren, s5_wen;
  logic [31:0] s1_iload, s1_dload, s1_raddr, s1_rstore, s5_iload, s5_dload, s5_raddr, s5_rstore;

  mem_arbiter #(.LAT(1), .CW(4)) u_lat1 (
    .CLK(clk), .RST(rst), .iREN(1'b0), .iaddr(32'h0),
    .dREN(s_dren), .dWEN(1'b0), .daddr(s_daddr), .dstore(32'h0),
    .ihit(s1_ihit), .dhit(s1_dhit), .iload(s1_iload), .dload(s1_dload),
    .ramREN(s1_ren), .ramWEN(s1_wen), .ramaddr(s1_raddr), .ramstore(s1_rstore),
    .ramload(s1_raddr + 32'h1)
  );

  mem_arbiter #(.LAT(5), .CW(4)) u_lat5 (
    .CLK(clk), .RST(rst), .iREN(1'b0), .iaddr(32'h0),
    .dREN(s_dren), .dWEN(1'b0), .daddr(s_daddr), .dstore(32'h0),
    .ihit(s5_ihit), .dhit(s5_dhit), .iload(s5_iload), .dload(s5_dload),
    .ramREN(s5_ren), .ramWEN(s5_wen), .ramaddr(s5_raddr), .ramstore(s5_rstore),
    .ramload(s5_raddr + 32'h1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_d;
    bit          is_wr;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  // Scoreboard consumer for the main instance.
  initial forever begin
    @(negedge clk);
    if (!rst && (bus.ihit || bus.dhit)) begin
      chk("hit_excl", 32'(bus.ihit & bus.dhit), 32'h0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'h1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("hit_port", 32'(bus.dhit), 32'(e.is_d));
        chk("hit_cycle", 32'(cyc), 32'(e.cyc));
        if (e.is_wr)     chk("hit_ramstore", bus.ramstore, e.data);
        else if (e.is_d) chk("hit_dload", bus.dload, e.data);
        else             chk("hit_iload", bus.iload, e.data);
      end
    end
  end

  bit sweep_on = 1'b0;
  int sw_c0 = 0;
  int l1_last = -1, l1_n = 0, l5_last = -1, l5_n = 0;

  initial forever begin
    @(negedge clk);
    if (sweep_on && (s1_dhit || s1_ihit)) begin
      chk("lat1_excl", 32'(s1_ihit & s1_dhit), 32'h0);
      if (l1_last < 0) chk("lat1_first", 32'(cyc - sw_c0), 32'd1);
      else             chk("lat1_gap", 32'(cyc - l1_last), 32'd2);
      chk("lat1_dload", s1_dload, s_daddr + 32'h1);
      l1_last = cyc;
      l1_n++;
    end
    if (sweep_on && (s5_dhit || s5_ihit)) begin
      chk("lat5_excl", 32'(s5_ihit & s5_dhit), 32'h0);
      if (l5_last < 0) chk("lat5_first", 32'(cyc - sw_c0), 32'd5);
      else             chk("lat5_gap", 32'(cyc - l5_last), 32'd6);
      chk("lat5_dload", s5_dload, s_daddr + 32'h1);
      l5_last = cyc;
      l5_n++;
    end
  end

  task automatic wait_hit(input bit want_d);
    bit got = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (want_d ? bus.dhit : bus.ihit) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) chk("hit_timeout", 32'(got), 32'h1);
  endtask

  int c0, c1;

  initial begin
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    bus.dREN = 1'b1; bus.dWEN = 1'b1;
    bus.daddr = 32'h100; bus.dstore = 32'h5555_AAAA;

    // Reset state with requests held: everything must stay quiet.
    #2;
    chk("rst_ramREN", 32'(bus.ramREN), 32'h0);
    chk("rst_ramWEN", 32'(bus.ramWEN), 32'h0);
    chk("rst_ramaddr", bus.ramaddr, 32'h0);
    chk("rst_ramstore", bus.ramstore, 32'h0);
    #10;
    chk("rst_hits", 32'({bus.ihit, bus.dhit}), 32'h0);
    chk("rst_state", 32'(u_dut.state), 32'(IDLE));
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Single instruction fetch.
    c0 = cyc;
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    sb.push_back('{1'b0, 1'b0, c0 + 2, 32'h8C22_0004});
    @(negedge clk);
    chk("f_c0_ramREN", 32'(bus.ramREN), 32'h0);
    @(negedge clk);
    chk("f_c1_ramREN", 32'(bus.ramREN), 32'h1);
    chk("f_c1_ramaddr", bus.ramaddr, 32'h40);
    chk("f_c1_ihit", 32'(bus.ihit), 32'h0);
    @(negedge clk);
    chk("f_c2_ramREN", 32'(bus.ramREN), 32'h1);
    chk("f_c2_ihit", 32'(bus.ihit), 32'h1);
    @(posedge clk); #1 bus.iREN = 1'b0;
    @(negedge clk);
    chk("f_c3_ihit", 32'(bus.ihit), 32'h0);

    // Simultaneous instruction and data read: data first.
    @(posedge clk); #1;
    c0 = cyc;
    bus.iREN = 1'b1; bus.iaddr = 32'h44;
    bus.dREN = 1'b1; bus.daddr = 32'h100;
    sb.push_back('{1'b1, 1'b0, c0 + 2, mem_model(32'h100)});
    sb.push_back('{1'b0, 1'b0, c0 + 5, mem_model(32'h44)});
    wait_hit(1'b1);
    @(posedge clk); #1 bus.dREN = 1'b0;
    @(negedge clk);
    chk("sim_c3_ramREN", 32'(bus.ramREN), 32'h0);
    wait_hit(1'b0);
    @(posedge clk); #1 bus.iREN = 1'b0;

    // Data write.
    @(posedge clk); #1;
    c0 = cyc;
    bus.dWEN = 1'b1; bus.daddr = 32'h200; bus.dstore = 32'hDEAD_BEEF;
    sb.push_back('{1'b1, 1'b1, c0 + 2, 32'hDEAD_BEEF});
    @(negedge clk);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("w_ramWEN", 32'(bus.ramWEN), 32'h1);
      chk("w_ramREN", 32'(bus.ramREN), 32'h0);
      chk("w_ramaddr", bus.ramaddr, 32'h200);
      chk("w_ramstore", bus.ramstore, 32'hDEAD_BEEF);
    end
    @(posedge clk); #1 bus.dWEN = 1'b0;

    // Abort: instruction request dropped in the first access cycle.
    @(posedge clk); #1;
    c0 = cyc;
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    @(posedge clk); #1 bus.iREN = 1'b0;
    @(negedge clk);
    chk("ab_c1_ramREN", 32'(bus.ramREN), 32'h0);
    chk("ab_c1_ihit", 32'(bus.ihit), 32'h0);
    @(negedge clk);
    chk("ab_c2_state", 32'(u_dut.state), 32'(IDLE));
    chk("ab_c2_ramREN", 32'(bus.ramREN), 32'h0);

    // Reset in the middle of a data access.
    @(posedge clk); #1;
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("mr_ramREN", 32'(bus.ramREN), 32'h0);
    chk("mr_ramaddr", bus.ramaddr, 32'h0);
    chk("mr_dhit", 32'(bus.dhit), 32'h0);
    chk("mr_state", 32'(u_dut.state), 32'(IDLE));
    @(posedge clk); #1 rst = 1'b0;
    c1 = cyc;
    sb.push_back('{1'b1, 1'b0, c1 + 2, mem_model(32'h300)});
    wait_hit(1'b1);
    @(posedge clk); #1 bus.dREN = 1'b0;

    // Back-to-back data reads on the LAT=1 and LAT=5 instances.
    @(posedge clk); #1;
    sw_c0 = cyc;
    s_dren = 1'b1;
    sweep_on = 1'b1;
    repeat (40) @(posedge clk);
    #1 sweep_on = 1'b0;
    s_dren = 1'b0;
    chk("lat1_count", 32'(l1_n), 32'd20);
    chk("lat5_count", 32'(l5_n), 32'd6);

    repeat (3) @(posedge clk);
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
